// File: rtl/gpio_reg_write_arbiter.sv
// Arbitrates host writes and a default-load sequence onto one register-file write port.
// Define GPIO_ARB_RR_EN for round-robin arbitration; otherwise the host has fixed priority over init.
module gpio_reg_write_arbiter #(
    parameter int                   AddrWidth = 14,
    parameter int                   BusWidth  = 32,
    parameter int                   NumIOReg  = 6,
    parameter logic [AddrWidth-1:0] BaseAddr  = 14'h1100,
    parameter int                   WrGap     = 2
) (
    input  logic                 CLOCK,
    input  logic                 reset_reg,
    input  logic                 h_req,
    input  logic [AddrWidth-1:0] h_addr,
    input  logic [BusWidth-1:0]  h_data,
    output logic                 h_ack,
    output logic                 h_err,
    input  logic                 init_start,
    input  logic [23:0]          init_value,
    output logic                 init_busy,
    output logic                 init_done,
    output logic                 wr_en,
    output logic [AddrWidth-1:0] wr_addr,
    output logic [23:0]          wr_data
);

    localparam int              IdxW    = $clog2(NumIOReg + 1);
    localparam logic [IdxW-1:0] IdxEnd  = IdxW'(NumIOReg);
    localparam logic [3:0]      GapLast = 4'(WrGap - 1);
    localparam logic [31:0]     AddrLo  = 32'(BaseAddr);
    localparam logic [31:0]     AddrHi  = 32'(BaseAddr) + 32'(4 * NumIOReg);

    typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

    state_t               state_q, state_d;
    logic [3:0]           gap_q, gap_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 busy_d;
    logic [23:0]          init_val_q, init_val_d;
    logic                 ack_d, err_d, done_d, wr_en_d;
    logic [AddrWidth-1:0] wr_addr_d;
    logic [23:0]          wr_data_d;
    logic                 host_pend, init_pend, grant_slot, pick_host, addr_ok;
    logic [31:0]          addr_ext;
    logic                 unused_hdata;
`ifdef GPIO_ARB_RR_EN
    logic                 rr_host_q, rr_host_d;
`endif

    assign unused_hdata = ^h_data[BusWidth-1:24];
    assign addr_ext     = 32'(h_addr);
    assign addr_ok      = (h_addr[1:0] == 2'b00) && (addr_ext >= AddrLo) && (addr_ext < AddrHi);
    // A request still held during its own ack cycle is the one just served.
    assign host_pend    = h_req && !h_ack;
    assign init_pend    = init_busy && (idx_q < IdxEnd);
    // The last GAP cycle arbitrates directly so strobes can be WrGap+1 cycles apart.
    assign grant_slot   = (state_q == IDLE) || ((state_q == GAP) && (gap_q == GapLast));
`ifdef GPIO_ARB_RR_EN
    assign pick_host    = host_pend && (!init_pend || rr_host_q);
`else
    assign pick_host    = host_pend;
`endif

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        idx_d      = idx_q;
        busy_d     = init_busy;
        init_val_d = init_val_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        done_d     = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
`ifdef GPIO_ARB_RR_EN
        rr_host_d  = rr_host_q;
`endif
        case (state_q)
            WRITE: begin
                state_d = GAP;
                gap_d   = '0;
            end
            GAP: begin
                if (gap_q == GapLast) begin
                    state_d = IDLE;
                    if (init_busy && (idx_q == IdxEnd)) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: ;
        endcase

        if (grant_slot && pick_host) begin
            ack_d = 1'b1;
`ifdef GPIO_ARB_RR_EN
            rr_host_d = 1'b0;
`endif
            if (addr_ok) begin
                state_d   = WRITE;
                wr_en_d   = 1'b1;
                wr_addr_d = h_addr;
                wr_data_d = h_data[23:0];
            end else begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end else if (grant_slot && init_pend) begin
            state_d   = WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = BaseAddr + AddrWidth'({idx_q, 2'b00});
            wr_data_d = init_val_q;
            idx_d     = idx_q + IdxW'(1);
`ifdef GPIO_ARB_RR_EN
            rr_host_d = 1'b1;
`endif
        end

        if (init_start && !init_busy) begin
            init_val_d = init_value;
            busy_d     = 1'b1;
            idx_d      = '0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (reset_reg) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            idx_q      <= '0;
            init_busy  <= 1'b0;
            init_val_q <= '0;
            h_ack      <= 1'b0;
            h_err      <= 1'b0;
            init_done  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
`ifdef GPIO_ARB_RR_EN
            rr_host_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            idx_q      <= idx_d;
            init_busy  <= busy_d;
            init_val_q <= init_val_d;
            h_ack      <= ack_d;
            h_err      <= err_d;
            init_done  <= done_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
`ifdef GPIO_ARB_RR_EN
            rr_host_q  <= rr_host_d;
`endif
        end
    end

endmodule

// File: tb/tb_gpio_reg_write_arbiter.sv
// Bench for gpio_reg_write_arbiter: directed scenarios plus randomized traffic against a timeline model.
module tb_gpio_reg_write_arbiter;
    localparam int         NR   = 6;
    localparam int         GAP  = 2;
    localparam logic [13:0] BASE = 14'h1100;

    logic        CLOCK = 1'b0;
    logic        reset_reg = 1'b1;
    logic        h_req = 1'b0;
    logic [13:0] h_addr = '0;
    logic [31:0] h_data = '0;
    logic        init_start = 1'b0;
    logic [23:0] init_value = '0;
    logic        h_ack, h_err, init_busy, init_done, wr_en;
    logic [13:0] wr_addr;
    logic [23:0] wr_data;

    gpio_reg_write_arbiter #(
        .AddrWidth(14), .BusWidth(32), .NumIOReg(NR), .BaseAddr(BASE), .WrGap(GAP)
    ) dut (
        .CLOCK(CLOCK), .reset_reg(reset_reg),
        .h_req(h_req), .h_addr(h_addr), .h_data(h_data), .h_ack(h_ack), .h_err(h_err),
        .init_start(init_start), .init_value(init_value), .init_busy(init_busy),
        .init_done(init_done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 CLOCK = ~CLOCK;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a grant edge blocks further grants for a number of edges; completion is scheduled.
    longint      edge_no = 0;
    longint      next_ok = 0;
    longint      done_edge = -1;
    bit          m_busy = 0;
    int          m_idx = 0;
    logic [23:0] m_val = '0;
    bit          m_rr_host = 1;
    bit          e_ack = 0, e_err = 0, e_done = 0, e_wen = 0;
    logic [13:0] e_addr = '0;
    logic [23:0] e_data = '0;

    always @(posedge CLOCK) begin : model_b
        bit hp, ip, pick_h, start_ok, hv;
        int a;
        if (reset_reg) begin
            next_ok = 0; done_edge = -1; m_busy = 0; m_idx = 0; m_val = '0; m_rr_host = 1;
            e_ack = 0; e_err = 0; e_done = 0; e_wen = 0; e_addr = '0; e_data = '0;
        end else begin
            hp = h_req && !e_ack;
            ip = m_busy && (m_idx < NR);
            start_ok = init_start && !m_busy;
            e_ack = 0; e_err = 0; e_done = 0; e_wen = 0;
            if (edge_no >= next_ok && (hp || ip)) begin
`ifdef GPIO_ARB_RR_EN
                pick_h = hp && (!ip || m_rr_host);
`else
                pick_h = hp;
`endif
                if (pick_h) begin
                    a = int'(h_addr);
                    hv = (a % 4 == 0) && (a >= int'(BASE)) && (a < int'(BASE) + 4 * NR);
                    e_ack = 1; m_rr_host = 0;
                    if (hv) begin
                        e_wen = 1; e_addr = h_addr; e_data = h_data[23:0];
                        next_ok = edge_no + GAP + 1;
                    end else begin
                        e_err = 1;
                        next_ok = edge_no + 1;
                    end
                end else begin
                    e_wen = 1; e_addr = BASE + 14'(4 * m_idx); e_data = m_val;
                    m_idx++; m_rr_host = 1;
                    next_ok = edge_no + GAP + 1;
                    if (m_idx == NR) done_edge = edge_no + GAP + 1;
                end
            end
            if (edge_no == done_edge) begin e_done = 1; m_busy = 0; end
            if (start_ok) begin m_busy = 1; m_idx = 0; m_val = init_value; end
        end
        edge_no++;
    end

    always @(negedge CLOCK) begin
        if (chk_en) begin
            chk("h_ack", 32'(h_ack), 32'(e_ack));
            chk("h_err", 32'(h_err), 32'(e_err));
            chk("init_done", 32'(init_done), 32'(e_done));
            chk("init_busy", 32'(init_busy), 32'(m_busy));
            chk("wr_en", 32'(wr_en), 32'(e_wen));
            chk("wr_addr", 32'(wr_addr), 32'(e_addr));
            chk("wr_data", 32'(wr_data), 32'(e_data));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic do_reset();
        reset_reg = 1'b1;
        cyc(2);
        reset_reg = 1'b0;
    endtask

    task automatic wait_ack(output bit got);
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge CLOCK);
            if (h_ack) got = 1;
        end
    endtask

    task automatic host_burst();
        bit got;
        for (int k = 0; k < 4; k++) begin
            h_req = 1'b1;
            h_addr = BASE + 14'(4 * k);
            h_data = 32'h00AB_C000 + 32'(k);
            wait_ack(got);
            chk("burst_ack_timeout", 32'(got), 32'd1);
        end
        h_req = 1'b0;
    endtask

    task automatic record_order();
        string seq = "";
        string exp;
        int n = 0;
`ifdef GPIO_ARB_RR_EN
        exp = "HIHIHIHIII";
`else
        exp = "HHHHIIIIII";
`endif
        for (int c = 0; c < 100 && n < 10; c++) begin
            @(negedge CLOCK);
            if (wr_en) begin
                seq = {seq, (wr_data == 24'h123456) ? "I" : "H"};
                n++;
            end
        end
        n_cmp++;
        if (seq != exp) begin
            n_bad++;
            $display("FAIL arb_order: got %s expected %s", seq, exp);
        end
    endtask

    initial begin
        int k, last, dones, strobes;
        bit got;
        cyc(2);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_ack_err_done_busy", 32'({h_ack, h_err, init_done, init_busy}), 32'd0);
        reset_reg = 1'b0;
        chk_en = 1'b1;

        // Single valid host write
        h_req = 1'b1; h_addr = 14'h1104; h_data = 32'hFF00_ABCD;
        cyc(1);
        chk("hw_wr_en", 32'(wr_en), 32'd1);
        chk("hw_wr_addr", 32'(wr_addr), 32'h1104);
        chk("hw_wr_data", 32'(wr_data), 32'h00ABCD);
        chk("hw_ack", 32'(h_ack), 32'd1);
        h_req = 1'b0;
        cyc(1);
        chk("hw_gap1", 32'(wr_en), 32'd0);
        cyc(1);
        chk("hw_gap2", 32'(wr_en), 32'd0);

        // Invalid addresses: out of range, then misaligned
        h_req = 1'b1; h_addr = 14'h1118; h_data = 32'h1234_5678;
        cyc(1);
        chk("inv1_ack_err_wen", 32'({h_ack, h_err, wr_en}), 32'b110);
        h_addr = 14'h1102;
        cyc(1);
        chk("inv_quiet", 32'(h_ack), 32'd0);
        cyc(1);
        chk("inv2_ack_err_wen", 32'({h_ack, h_err, wr_en}), 32'b110);
        h_req = 1'b0;
        cyc(1);

        // Default load, with an ignored restart mid-sequence
        init_value = 24'h00000F; init_start = 1'b1;
        cyc(1);
        init_start = 1'b0;
        chk("init_busy_set", 32'(init_busy), 32'd1);
        k = 0; last = -1; dones = 0;
        for (int c = 0; c < 40; c++) begin
            init_start = 1'b0;
            if (wr_en) begin
                chk("init_addr", 32'(wr_addr), 32'(BASE) + 32'(4 * k));
                chk("init_data", 32'(wr_data), 32'h00000F);
                if (k > 0) chk("init_spacing", 32'(c - last), 32'd3);
                last = c; k++;
                if (k == 2) begin init_value = 24'hAAAAAA; init_start = 1'b1; end
            end
            if (init_done) dones++;
            cyc(1);
        end
        chk("init_strobes", 32'(k), 32'd6);
        chk("init_done_pulses", 32'(dones), 32'd1);
        chk("init_busy_clear", 32'(init_busy), 32'd0);

        // Host traffic contending with an init sequence
        do_reset();
        init_value = 24'h123456; init_start = 1'b1;
        cyc(1);
        init_start = 1'b0;
        fork
            host_burst();
            record_order();
        join
        cyc(10);

        // Reset in the GAP after the third init write
        do_reset();
        init_value = 24'h5A5A5A; init_start = 1'b1;
        cyc(1);
        init_start = 1'b0;
        k = 0;
        for (int c = 0; c < 40 && k < 3; c++) begin
            cyc(1);
            if (wr_en) k++;
        end
        chk("rst_mid_third", 32'(k), 32'd3);
        cyc(1);
        reset_reg = 1'b1;
        cyc(1);
        reset_reg = 1'b0;
        chk("rst_mid_outs", 32'({h_ack, h_err, init_done, init_busy, wr_en}), 32'd0);
        chk("rst_mid_addr_data", 32'({wr_addr, wr_data} != '0), 32'd0);
        strobes = 0; dones = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(1);
            if (wr_en) strobes++;
            if (init_done) dones++;
        end
        chk("rst_mid_no_strobe", 32'(strobes), 32'd0);
        chk("rst_mid_no_done", 32'(dones), 32'd0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!h_req || h_ack) begin
                if ($urandom_range(0, 3) != 0) begin
                    h_req = 1'b1;
                    if ($urandom_range(0, 3) != 0) h_addr = BASE + 14'(4 * $urandom_range(0, NR - 1));
                    else h_addr = 14'($urandom);
                    h_data = $urandom;
                end else begin
                    h_req = 1'b0;
                end
            end
            init_start = ($urandom_range(0, 29) == 0);
            if (init_start) init_value = 24'($urandom);
            reset_reg = ($urandom_range(0, 399) == 0);
            cyc(1);
        end
        reset_reg = 1'b0; h_req = 1'b0; init_start = 1'b0;
        cyc(10);
        chk_en = 1'b0;
        got = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_reg_write_arbiter.md
GPIO_REG_WRITE_ARBITER -- requirements
Module: gpio_reg_write_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- AddrWidth, 14, bus address width.
- BusWidth, 32, host data width.
- NumIOReg, 6, number of 24-bit GPIO DDR registers.
- BaseAddr, 14'h1100, address of DDR register 0; register k is at BaseAddr+4*k.
- WrGap, 2, idle cycles forced after every write strobe (1..15).
REQ-002 Ports (name, direction, width, meaning), one per line:
- CLOCK, in, 1, sole clock.
- reset_reg, in, 1, synchronous active-high reset.
- h_req, in, 1, host write request.
- h_addr, in, AddrWidth, host byte address.
- h_data, in, BusWidth, host write data.
- h_ack, out, 1, one-cycle host acknowledge.
- h_err, out, 1, one-cycle pulse with h_ack when h_addr is invalid.
- init_start, in, 1, pulse that starts the default load of all registers.
- init_value, in, 24, default DDR value, latched at init_start.
- init_busy, out, 1, default load in progress.
- init_done, out, 1, one-cycle completion pulse.
- wr_en, out, 1, one-cycle register-file write strobe.
- wr_addr, out, AddrWidth, register-file address.
- wr_data, out, 24, register-file write data.
REQ-003 One clock and one synchronous active-high reset: all state updates on the rising edge of CLOCK, and reset_reg is sampled only on that edge.

Function
REQ-004 FSM states: IDLE, WRITE, GAP; all outputs are registered.
REQ-005 A host request is pending when h_req=1 in IDLE; an init request is pending when init_busy=1 and idx<NumIOReg.
REQ-006 A host address is valid when h_addr[1:0]=0 and BaseAddr <= h_addr < BaseAddr+4*NumIOReg.
REQ-007 IDLE with a request pending at edge N -> WRITE during cycle N+1:
- wr_en=1 for exactly that cycle.
- wr_addr/wr_data hold the granted address and data bits [23:0].
- h_ack=1 in that same cycle when the host is granted.
REQ-008 WRITE -> GAP, which lasts exactly WrGap cycles with wr_en=0, then -> IDLE; the earliest next strobe is therefore at cycle N+2+WrGap.
REQ-009 Invalid host address: in cycle N+1, h_ack=1 and h_err=1, wr_en stays 0, and the FSM returns to IDLE with no GAP.
REQ-010 The host holds h_req/h_addr/h_data stable until h_ack; h_req still high in the cycle after h_ack is a new request.
REQ-011 init_start in any cycle with init_busy=0:
- latches init_value;
- sets init_busy=1 and idx=0.
REQ-012 init_start while init_busy=1 is ignored.
REQ-013 Each init grant writes wr_addr=BaseAddr+4*idx and wr_data=latched init_value, then increments idx.
REQ-014 Completion: after the GAP of the last init write (idx=NumIOReg-1), init_busy=0 and init_done=1 for one cycle, coincident with the return to IDLE.
REQ-015 Simultaneous pending host and init requests are arbitrated per REQ-019.
REQ-016 wr_addr and wr_data hold their last values when wr_en=0.

Reset
REQ-017 While reset_reg=1 at an edge, the block is cleared:
- state=IDLE, idx=0, init_busy=0, latched value=0;
- h_ack, h_err, init_done, wr_en, wr_addr, wr_data all 0;
- round-robin pointer set to host.
REQ-018 Reset mid-operation (WRITE or GAP, or during an init sequence) abandons the operation with no further strobe, and the pending init is lost; reset wins over a simultaneous init_start or h_req.

Configuration
REQ-019 Macro GPIO_ARB_RR_EN selects the arbitration policy:
- Defined: round-robin; when both requests are pending, the grant goes to the requester not granted last, and a single pending requester is always granted.
- Undefined: fixed priority, host over init; init can be starved by continuous host traffic.

Verification
REQ-020 Reset, then h_req with h_addr=14'h1104, h_data=32'hFF00_ABCD -> in cycle 1 after the grant edge: wr_en=1, wr_addr=14'h1104, wr_data=24'h00ABCD, h_ack=1; wr_en=0 for the next 2 cycles.
REQ-021 h_req with h_addr=14'h1118, then 14'h1102 -> each gets h_ack=1 and h_err=1 with wr_en=0, and the next request is grantable one cycle later.
REQ-022 init_start with init_value=24'h00000F -> six strobes at 14'h1100..14'h1114 spaced 3 cycles apart, then one init_done pulse and init_busy=0; a second init_start mid-sequence has no effect.
REQ-023 Host requests held continuously during an init sequence -> with GPIO_ARB_RR_EN, grants alternate host/init; without it, all host requests are granted first and init writes follow.
REQ-024 reset_reg=1 for one cycle during the GAP after the third init write -> no further strobes, init_busy=0, no init_done pulse, and all outputs are 0 on the next cycle.
